mem_port_arbiter: RTL and testbench

//  Shares the core's single-port data memory between the fetch requester (IF) and the load/store requester (D).

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between fetch (IF) and load/store (D),
// sequencing each access and handling store lane steering and load extension.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_misalign,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  // state | meaning
  // IDLE  | arbitrate, grant at most one requester
  // ISSUE | one-cycle read or write strobe to memory
  // WAIT  | MEM_LAT cycles, read data captured in the last one
  // RESP  | one-cycle rvalid to the owner
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic          owner_d, we_q, uns_q, err_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          force_if, misalign_in;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   load_v;
  logic [3:0]    strb_v;
  logic [31:0]   wrep_v;

  // IF is forced only once D has won STARVE_MAX times in a row while IF waited
  assign force_if    = if_req && (starve_cnt == SW'(STARVE_MAX));
  assign misalign_in = (d_size == 2'b11) || (d_size == 2'b01 && d_addr[0]) ||
                       (d_size == 2'b10 && d_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    d_gnt    = 1'b0;
    if_gnt   = 1'b0;
    case (state)
      IDLE: begin
        d_gnt  = rst && d_req && !force_if;
        if_gnt = rst && if_req && !d_gnt;
        if (d_gnt)       state_nx = misalign_in ? RESP : ISSUE;
        else if (if_gnt) state_nx = ISSUE;
      end
      ISSUE:   state_nx = WAIT;
      WAIT:    if (wait_cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    byte_v = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_v = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_v = uns_q ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_v = uns_q ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_v = mem_rdata;
    endcase
    case (size_q)
      2'b00:   begin strb_v = 4'b0001 << addr_q[1:0]; wrep_v = {4{wdata_q[7:0]}};  end
      2'b01:   begin strb_v = 4'b0011 << addr_q[1:0]; wrep_v = {2{wdata_q[15:0]}}; end
      default: begin strb_v = 4'b1111;                wrep_v = wdata_q;             end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt   <= '0;
      starve_cnt <= '0;
      owner_d    <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (d_gnt) begin
        owner_d <= 1'b1;
        we_q    <= d_we;
        uns_q   <= d_unsigned;
        err_q   <= misalign_in;
        size_q  <= d_size;
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        rdata_q <= '0;
        if (if_req && starve_cnt < SW'(STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
      end else if (if_gnt) begin
        owner_d    <= 1'b0;
        we_q       <= 1'b0;
        uns_q      <= 1'b0;
        err_q      <= 1'b0;
        size_q     <= 2'b10;
        addr_q     <= if_addr;
        rdata_q    <= '0;
        starve_cnt <= '0;
      end
      if (state == ISSUE) wait_cnt <= CW'(MEM_LAT - 1);
      else if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
      if (state == WAIT && wait_cnt == '0 && !we_q) rdata_q <= load_v;
    end
  end

  assign mem_re     = (state == ISSUE) && !we_q;
  assign mem_we     = (state == ISSUE) && we_q;
  assign mem_addr   = (state == ISSUE) ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata  = mem_we ? wrep_v : 32'd0;
  assign mem_wstrb  = mem_we ? strb_v : 4'd0;
  assign d_rvalid   = (state == RESP) && owner_d;
  assign if_rvalid  = (state == RESP) && !owner_d;
  assign d_rdata    = d_rvalid ? rdata_q : 32'd0;
  assign if_rdata   = if_rvalid ? rdata_q : 32'd0;
  assign d_misalign = d_rvalid && err_q;
  assign busy       = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, if_gnt, if_rvalid, d_req, d_we, d_unsigned, d_gnt, d_rvalid;
  logic        d_misalign, mem_re, mem_we, busy;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  d_size;
  logic [3:0]  mem_wstrb;

  logic        rst3, if_req3, if_gnt3, if_rvalid3, d_req3, d_we3, d_unsigned3, d_gnt3, d_rvalid3;
  logic        d_misalign3, mem_re3, mem_we3, busy3;
  logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [1:0]  d_size3;
  logic [3:0]  mem_wstrb3;

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_misalign(d_misalign),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy));

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
    .clk(clk), .rst(rst3), .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3), .d_req(d_req3), .d_we(d_we3),
    .d_addr(d_addr3), .d_wdata(d_wdata3), .d_size(d_size3), .d_unsigned(d_unsigned3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3), .d_misalign(d_misalign3),
    .mem_re(mem_re3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_wstrb(mem_wstrb3), .mem_rdata(mem_rdata3), .busy(busy3));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] size, input logic uns,
                       input logic [31:0] rd, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    step();
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; d_size = size;
    d_unsigned = uns; mem_rdata = rd;
    #1;
    chk({tag, "_gnt"}, d_gnt, 1'b1);
    step();
    d_req = 1'b0; d_addr = 32'hFFFF_FFFF; d_wdata = 32'h0; d_size = 2'b11;
    #1;
    chk({tag, "_strobe"}, {mem_we, mem_re}, we ? 2'b10 : 2'b01);
    chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    chk({tag, "_wstrb"}, mem_wstrb, exp_strb);
    chk({tag, "_wdata"}, mem_wdata, exp_wdata);
    step();
    #1;
    chk({tag, "_wait"}, {mem_re, mem_we, d_rvalid}, 3'b000);
    step();
    #1;
    chk({tag, "_rvalid"}, {d_rvalid, d_misalign, if_rvalid}, 3'b100);
    chk({tag, "_rdata"}, d_rdata, exp_rdata);
  endtask

  task automatic d_err(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size);
    step();
    d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_wdata = 32'h1234_5678;
    #1;
    chk({tag, "_gnt"}, d_gnt, 1'b1);
    step();
    d_req = 1'b0;
    #1;
    chk({tag, "_resp"}, {d_rvalid, d_misalign, mem_re, mem_we}, 4'b1100);
    chk({tag, "_rdata"}, d_rdata, 32'h0);
    step();
    #1;
    chk({tag, "_idle"}, {busy, d_rvalid}, 2'b00);
  endtask

  logic [9:0] exp_order = 10'b1111011110;
  logic       got_order[10];
  int         ngr;

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_size = 2'b10; d_unsigned = 1'b0; mem_rdata = '0;
    rst3 = 1'b0; if_req3 = 1'b0; if_addr3 = '0; d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = '0;
    d_wdata3 = '0; d_size3 = 2'b10; d_unsigned3 = 1'b0; mem_rdata3 = '0;
    step(); step();
    if_req = 1'b1;
    #1;
    chk("reset_outs", {busy, mem_re, mem_we, d_rvalid, if_rvalid, d_gnt, if_gnt, d_misalign}, 8'h00);
    chk("reset_buses", mem_addr | mem_wdata | d_rdata | if_rdata | {28'd0, mem_wstrb}, 32'h0);
    step();
    if_req = 1'b0; rst = 1'b1; rst3 = 1'b1;

    d_txn("t1_lw",  1'b0, 32'h104, 32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 4'h0, 32'h0, 32'hDEADBEEF);
    d_txn("t2_lb",  1'b0, 32'h103, 32'h0,        2'b00, 1'b0, 32'h80FF1234, 4'h0, 32'h0, 32'hFFFFFF80);
    d_txn("t2_lbu", 1'b0, 32'h103, 32'h0,        2'b00, 1'b1, 32'h80FF1234, 4'h0, 32'h0, 32'h00000080);
    d_txn("lb1",    1'b0, 32'h101, 32'h0,        2'b00, 1'b0, 32'h80FF1234, 4'h0, 32'h0, 32'h00000012);
    d_txn("lh_hi",  1'b0, 32'h102, 32'h0,        2'b01, 1'b0, 32'h80FF1234, 4'h0, 32'h0, 32'hFFFF80FF);
    d_txn("lhu_hi", 1'b0, 32'h102, 32'h0,        2'b01, 1'b1, 32'h80FF1234, 4'h0, 32'h0, 32'h000080FF);
    d_txn("lh_lo",  1'b0, 32'h100, 32'h0,        2'b01, 1'b0, 32'h0000F234, 4'h0, 32'h0, 32'hFFFFF234);
    d_txn("t3_sh",  1'b1, 32'h102, 32'h0000ABCD, 2'b01, 1'b0, 32'hFFFFFFFF, 4'b1100, 32'hABCDABCD, 32'h0);
    d_txn("sb",     1'b1, 32'h101, 32'h1122335A, 2'b00, 1'b0, 32'hFFFFFFFF, 4'b0010, 32'h5A5A5A5A, 32'h0);
    d_txn("sw",     1'b1, 32'h208, 32'hCAFEF00D, 2'b10, 1'b0, 32'hFFFFFFFF, 4'b1111, 32'hCAFEF00D, 32'h0);

    d_err("t5_lw",  1'b0, 32'h101, 2'b10);
    d_err("ill_sz", 1'b0, 32'h100, 2'b11);
    d_err("sh_mis", 1'b1, 32'h103, 2'b01);

    // IF fetch ignores the low address bits
    step();
    if_req = 1'b1; if_addr = 32'h13; mem_rdata = 32'h12345678;
    #1;
    chk("if_gnt", {if_gnt, d_gnt}, 2'b10);
    step();
    if_req = 1'b0;
    #1;
    chk("if_issue", {mem_re, mem_we, mem_wstrb}, 6'b100000);
    chk("if_addr", mem_addr, 32'h10);
    step(); step();
    #1;
    chk("if_rvalid", {if_rvalid, d_rvalid}, 2'b10);
    chk("if_rdata", if_rdata, 32'h12345678);

    step();
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_size = 2'b10;
    ngr = 0;
    for (int c = 0; c < 200 && ngr < 10; c++) begin
      #1;
      if (d_gnt && if_gnt) chk("t4_double_gnt", {d_gnt, if_gnt}, 2'b10);
      if (d_gnt || if_gnt) begin
        got_order[ngr] = d_gnt;
        ngr++;
      end
      step();
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("t4_count", ngr, 10);
    for (int i = 0; i < ngr && i < 10; i++) chk($sformatf("t4_order%0d", i), got_order[i], exp_order[9-i]);
    step(); step(); step(); step();
    #1;
    chk("t4_idle", busy, 1'b0);

    step();
    d_req3 = 1'b1; d_addr3 = 32'h104; d_size3 = 2'b10; d_we3 = 1'b0; mem_rdata3 = 32'hA5A5A5A5;
    #1;
    chk("t6_gnt", d_gnt3, 1'b1);
    step();
    d_req3 = 1'b0;
    #1;
    chk("t6_issue", mem_re3, 1'b1);
    step();
    #1;
    chk("t6_wait", {busy3, mem_re3, d_rvalid3}, 3'b100);
    step();
    rst3 = 1'b0; if_req3 = 1'b1; if_addr3 = 32'h80;
    step();
    #1;
    chk("t6_rst_outs", {busy3, mem_re3, mem_we3, d_rvalid3, if_rvalid3, d_gnt3, if_gnt3, d_misalign3}, 8'h00);
    chk("t6_rst_buses", mem_addr3 | mem_wdata3 | d_rdata3 | if_rdata3 | {28'd0, mem_wstrb3}, 32'h0);
    step();
    rst3 = 1'b1;
    #1;
    chk("t6_if_gnt", {if_gnt3, d_rvalid3}, 2'b10);
    step();
    if_req3 = 1'b0;
    #1;
    chk("t6_if_issue", mem_addr3, 32'h80);
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      chk($sformatf("t6_quiet%0d", c), {d_rvalid3, if_rvalid3}, 2'b00);
    end
    step();
    #1;
    chk("t6_if_rvalid", {if_rvalid3, d_rvalid3}, 2'b10);
    chk("t6_if_rdata", if_rdata3, 32'hA5A5A5A5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
